// File: rtl/victim_writeback_buffer.sv
// Write-back buffer between the victim cache and physical memory: absorbs evicted
// lines, coalesces repeat writes, serves read hits and drains oldest-first when idle.
module victim_writeback_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     u_read,
  input  logic                     u_write,
  input  logic [ADDR_W-1:0]        u_address,
  input  logic [LINE_W-1:0]        u_wdata,
  output logic [LINE_W-1:0]        u_rdata,
  output logic                     u_resp,
  output logic                     pmem_read,
  output logic                     pmem_write,
  output logic [ADDR_W-1:0]        pmem_address,
  output logic [LINE_W-1:0]        pmem_wdata,
  input  logic [LINE_W-1:0]        pmem_rdata,
  input  logic                     pmem_resp,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = ADDR_W - 4;

  typedef enum logic [1:0] {IDLE, ACK, PMEM_READ, DRAIN} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [DEPTH-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [DEPTH];
  logic [LINE_W-1:0]  r_data [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [LINE_W-1:0]  r_ackData;

  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic [PTR_W-1:0]   w_hitIdx;
  logic               w_rdHit;
  logic               w_wrHit;
  logic               w_enq;
  logic               w_deq;

  assign w_tag = u_address[ADDR_W-1:4];
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

  // Coalescing guarantees at most one valid entry matches a given line.
  always_comb begin
    w_hit    = 1'b0;
    w_hitIdx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_tag[i] == w_tag)) begin
        w_hit    = 1'b1;
        w_hitIdx = PTR_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_rdHit     = 1'b0;
    w_wrHit     = 1'b0;
    w_enq       = 1'b0;
    w_deq       = 1'b0;
    case (r_state)
      IDLE: begin
        if (u_read) begin
          if (w_hit) begin
            w_rdHit     = 1'b1;
            w_nextState = ACK;
          end else begin
            w_nextState = PMEM_READ;
          end
        end else if (u_write) begin
          if (w_hit) begin
            w_wrHit     = 1'b1;
            w_nextState = ACK;
          end else if (!full) begin
            w_enq       = 1'b1;
            w_nextState = ACK;
          end else begin
            w_nextState = DRAIN;
          end
        end else if (!empty) begin
          w_nextState = DRAIN;
        end
      end
      ACK:       w_nextState = IDLE;
      PMEM_READ: if (pmem_resp) w_nextState = IDLE;
      DRAIN: begin
        if (pmem_resp) begin
          w_deq       = 1'b1;
          w_nextState = IDLE;
        end
      end
      default:   w_nextState = IDLE;
    endcase
  end

  always_comb begin
    u_resp       = (r_state == ACK) || ((r_state == PMEM_READ) && pmem_resp);
    u_rdata      = '0;
    pmem_read    = (r_state == PMEM_READ);
    pmem_write   = (r_state == DRAIN);
    pmem_address = '0;
    pmem_wdata   = '0;
    if (r_state == ACK) begin
      u_rdata = r_ackData;
    end else if ((r_state == PMEM_READ) && pmem_resp) begin
      u_rdata = pmem_rdata;
    end
    if (r_state == PMEM_READ) begin
      pmem_address = u_address;
    end else if (r_state == DRAIN) begin
      pmem_address = {r_tag[r_head], 4'b0000};
      pmem_wdata   = r_data[r_head];
    end
  end

  // Enqueue happens only from IDLE and dequeue only from DRAIN, so they never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_ackData <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_rdHit) begin
        r_ackData <= r_data[w_hitIdx];
      end else if (w_wrHit || w_enq) begin
        r_ackData <= '0;
      end
      if (w_wrHit) begin
        r_data[w_hitIdx] <= u_wdata;
      end
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_tag[r_tail]   <= w_tag;
        r_data[r_tail]  <= u_wdata;
        r_tail          <= r_tail + PTR_W'(1);
        r_count         <= r_count + CNT_W'(1);
      end
      if (w_deq) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
        r_count         <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_victim_writeback_buffer.sv
// Scoreboard bench for victim_writeback_buffer: expected upstream responses and
// memory transactions are queued by the stimulus and checked by a monitor.
module tb_victim_writeback_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         u_read;
  logic         u_write;
  logic [15:0]  u_address;
  logic [127:0] u_wdata;
  logic [127:0] u_rdata;
  logic         u_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         full;
  logic         empty;
  logic [2:0]   count;

  typedef struct {
    logic         isWrite;
    logic [15:0]  addr;
    logic [127:0] data;
  } pmemExp_t;

  pmemExp_t     pmQ[$];
  logic [127:0] upQ[$];
  int           checks = 0;
  int           errors = 0;
  bit           respEnable = 1'b0;
  int           respDelay = 2;
  int           waitCnt = 0;
  bit           sawPmemRead = 1'b0;
  bit           sawPmemWrite = 1'b0;
  int           waited;

  localparam logic [127:0] DATA_A = {8{16'hAAAA}};
  localparam logic [127:0] DATA_B = {8{16'hBBBB}};
  localparam logic [127:0] DATA_C = {8{16'hCCCC}};
  localparam logic [127:0] DATA_D = 128'h8000_8000_8000_8000_8000_8000_8000_8000;
  localparam logic [127:0] DATA_E0 = {4{32'hE000_0000}};
  localparam logic [127:0] DATA_E1 = {4{32'hE111_1111}};
  localparam logic [127:0] DATA_E2 = {4{32'hE222_2222}};
  localparam logic [127:0] DATA_E3 = {4{32'hE333_3333}};
  localparam logic [127:0] DATA_E4 = {4{32'hE444_4444}};

  victim_writeback_buffer #(.DEPTH(4), .ADDR_W(16), .LINE_W(128)) dut (
    .clk(clk), .reset(reset),
    .u_read(u_read), .u_write(u_write), .u_address(u_address), .u_wdata(u_wdata),
    .u_rdata(u_rdata), .u_resp(u_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  // Memory model returns its address replicated as read data.
  function automatic logic [127:0] memData(input logic [15:0] a);
    return {8{a}};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: answers a held strobe after respDelay cycles.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (respEnable && !reset && (pmem_read || pmem_write)) begin
        if (waitCnt >= respDelay) begin
          pmem_resp  = 1'b1;
          pmem_rdata = memData(pmem_address);
          waitCnt    = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a transaction.
  always @(negedge clk) begin
    pmemExp_t     e;
    logic [127:0] expData;
    if (pmem_read)  sawPmemRead  = 1'b1;
    if (pmem_write) sawPmemWrite = 1'b1;
    if (u_resp) begin
      if (upQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedResp: got u_resp with rdata %h, expected none", u_rdata);
      end else begin
        expData = upQ.pop_front();
        checkOutput("u_rdata", u_rdata, expData);
      end
    end
    if (pmem_resp && (pmem_read || pmem_write)) begin
      if (pmQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedPmem: got write=%0b addr %h, expected none", pmem_write, pmem_address);
      end else begin
        e = pmQ.pop_front();
        checkOutput("pmemKind", {127'b0, pmem_write}, {127'b0, e.isWrite});
        checkOutput("pmemAddr", {112'b0, pmem_address}, {112'b0, e.addr});
        if (e.isWrite) checkOutput("pmemWdata", pmem_wdata, e.data);
      end
    end
  end

  task automatic applyStimulus(input bit isRead, input logic [15:0] addr,
                               input logic [127:0] wdata, output int nWait);
    @(posedge clk);
    #1;
    u_read    = isRead;
    u_write   = !isRead;
    u_address = addr;
    u_wdata   = wdata;
    nWait     = 0;
    do begin
      @(negedge clk);
      nWait++;
    end while (!u_resp && nWait < 200);
    if (!u_resp) begin
      checks++;
      errors++;
      $display("[TB] FAIL respTimeout: got no u_resp for addr %h, expected one", addr);
    end
  endtask

  task automatic releaseReq();
    @(posedge clk);
    #1;
    u_read  = 1'b0;
    u_write = 1'b0;
  endtask

  task automatic waitEmpty(input string name);
    int n = 0;
    while (!(empty && !pmem_write) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "Empty"}, {127'b0, empty}, 128'd1);
    checkOutput({name, "Count"}, {125'b0, count}, 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; u_read = 1'b0; u_write = 1'b0; u_address = '0; u_wdata = '0;
    #13;
    checkOutput("rstResp",  {127'b0, u_resp}, 128'd0);
    checkOutput("rstRdata", u_rdata, 128'd0);
    checkOutput("rstPrd",   {127'b0, pmem_read}, 128'd0);
    checkOutput("rstPwr",   {127'b0, pmem_write}, 128'd0);
    checkOutput("rstPaddr", {112'b0, pmem_address}, 128'd0);
    checkOutput("rstPwd",   pmem_wdata, 128'd0);
    checkOutput("rstFull",  {127'b0, full}, 128'd0);
    checkOutput("rstEmpty", {127'b0, empty}, 128'd1);
    checkOutput("rstCount", {125'b0, count}, 128'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset during drain");
    respEnable = 1'b0;
    upQ.push_back('0);
    upQ.push_back('0);
    applyStimulus(1'b0, 16'h0200, DATA_A, waited);
    applyStimulus(1'b0, 16'h0210, DATA_B, waited);
    releaseReq();
    begin
      int n = 0;
      while (!pmem_write && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("t1DrainStarted", {127'b0, pmem_write}, 128'd1);
    checkOutput("t1CountBefore", {125'b0, count}, 128'd2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t1Empty", {127'b0, empty}, 128'd1);
    checkOutput("t1Count", {125'b0, count}, 128'd0);
    checkOutput("t1Pwr",   {127'b0, pmem_write}, 128'd0);
    checkOutput("t1Paddr", {112'b0, pmem_address}, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    sawPmemWrite = 1'b0;
    respEnable   = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("t1NoDrain", {127'b0, sawPmemWrite}, 128'd0);

    $display("[TB] single write then drain");
    upQ.push_back('0);
    pmQ.push_back('{1'b1, 16'h1230, DATA_A});
    applyStimulus(1'b0, 16'h1230, DATA_A, waited);
    checkOutput("t2Latency", waited, 128'd2);
    checkOutput("t2Count", {125'b0, count}, 128'd1);
    releaseReq();
    waitEmpty("t2");

    $display("[TB] coalescing writes");
    upQ.push_back('0);
    upQ.push_back('0);
    pmQ.push_back('{1'b1, 16'h1230, DATA_B});
    applyStimulus(1'b0, 16'h1230, DATA_A, waited);
    checkOutput("t3LatA", waited, 128'd2);
    applyStimulus(1'b0, 16'h1238, DATA_B, waited);
    checkOutput("t3LatB", waited, 128'd2);
    checkOutput("t3Count", {125'b0, count}, 128'd1);
    releaseReq();
    waitEmpty("t3");

    $display("[TB] read hit");
    sawPmemRead = 1'b0;
    upQ.push_back('0);
    upQ.push_back(DATA_C);
    pmQ.push_back('{1'b1, 16'h4000, DATA_C});
    applyStimulus(1'b0, 16'h4000, DATA_C, waited);
    applyStimulus(1'b1, 16'h4004, '0, waited);
    checkOutput("t4Latency", waited, 128'd2);
    checkOutput("t4NoPmemRead", {127'b0, sawPmemRead}, 128'd0);
    releaseReq();
    waitEmpty("t4");

    $display("[TB] full buffer stall");
    for (int i = 0; i < 5; i++) upQ.push_back('0);
    pmQ.push_back('{1'b1, 16'h0000, DATA_E0});
    pmQ.push_back('{1'b1, 16'h0010, DATA_E1});
    pmQ.push_back('{1'b1, 16'h0020, DATA_E2});
    pmQ.push_back('{1'b1, 16'h0030, DATA_E3});
    pmQ.push_back('{1'b1, 16'h0040, DATA_E4});
    applyStimulus(1'b0, 16'h0000, DATA_E0, waited);
    applyStimulus(1'b0, 16'h0010, DATA_E1, waited);
    applyStimulus(1'b0, 16'h0020, DATA_E2, waited);
    applyStimulus(1'b0, 16'h0030, DATA_E3, waited);
    checkOutput("t5Full", {127'b0, full}, 128'd1);
    checkOutput("t5Count4", {125'b0, count}, 128'd4);
    applyStimulus(1'b0, 16'h0040, DATA_E4, waited);
    checkOutput("t5Stalled", {127'b0, (waited > 2)}, 128'd1);
    checkOutput("t5CountAfter", {125'b0, count}, 128'd4);
    releaseReq();
    waitEmpty("t5");

    $display("[TB] read miss with buffered entries");
    upQ.push_back('0);
    upQ.push_back('0);
    upQ.push_back(DATA_D);
    pmQ.push_back('{1'b0, 16'h8000, '0});
    pmQ.push_back('{1'b1, 16'h0100, DATA_A});
    pmQ.push_back('{1'b1, 16'h0110, DATA_B});
    applyStimulus(1'b0, 16'h0100, DATA_A, waited);
    applyStimulus(1'b0, 16'h0110, DATA_B, waited);
    applyStimulus(1'b1, 16'h8000, '0, waited);
    checkOutput("t6Count", {125'b0, count}, 128'd2);
    releaseReq();
    waitEmpty("t6");

    repeat (5) @(negedge clk);
    checkOutput("upQDrained", upQ.size(), 128'd0);
    checkOutput("pmQDrained", pmQ.size(), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/victim_writeback_buffer.md
Name: victim_writeback_buffer

Overview:
- Write-back buffer between the victim cache's physical-memory side and physical memory.
- Absorbs evicted 128-bit lines so victim-cache evictions complete in one cycle instead of waiting for memory.
- Coalesces repeat writes to a buffered line and drains entries to memory oldest-first when idle.
- Returns buffered line data on a read hit and forwards read misses to memory.

Parameters:
DEPTH, 4, number of line entries (power of 2, >= 2)
ADDR_W, 16, byte address width
LINE_W, 128, line width in bits (16-byte lines; line match uses address[ADDR_W-1:4])

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
u_read  in  1  upstream line read request; held until u_resp
u_write  in  1  upstream line write (eviction) request; held until u_resp
u_address  in  ADDR_W  upstream line address
u_wdata  in  LINE_W  upstream write data
u_rdata  out  LINE_W  read data; valid while u_resp=1
u_resp  out  1  single-cycle completion pulse
pmem_read  out  1  memory read strobe; held until pmem_resp
pmem_write  out  1  memory write strobe; held until pmem_resp
pmem_address  out  ADDR_W  memory address
pmem_wdata  out  LINE_W  memory write data
pmem_rdata  in  LINE_W  memory read data; valid with pmem_resp
pmem_resp  in  1  memory completion pulse
full  out  1  count==DEPTH
empty  out  1  count==0
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Storage: DEPTH entries {valid, line address, data} in circular FIFO order with head/tail pointers that wrap modulo DEPTH.
- Coalescing keeps at most one entry per line.
- Reset (asynchronous, any state, including mid-transaction): all entries invalid, head=tail=0, state IDLE.
  - Outputs at reset: u_resp=0, u_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, full=0, empty=1, count=0.
  - An in-flight memory transaction is abandoned.
- FSM states: IDLE, ACK, PMEM_READ, DRAIN.
- IDLE, priority order:
  1. u_read, line matches an entry: latch that entry's data -> ACK.
  2. u_read, no match -> PMEM_READ.
  3. u_write, line matches an entry: overwrite that entry's data in place (count unchanged) -> ACK.
  4. u_write, no match, not full: enqueue at tail, count+1 -> ACK.
  5. u_write, no match, full -> DRAIN (write stays pending and is re-evaluated on return to IDLE).
  6. No request and !empty -> DRAIN.
  7. Otherwise stay IDLE.
  - u_read and u_write both high is illegal; the block services the read.
- ACK:
  - u_resp=1 for exactly one cycle.
  - u_rdata = latched hit data for a read; u_rdata = 0 for a write.
  - Next state IDLE.
  - Latency: request sampled in IDLE cycle N, u_resp in cycle N+1.
- PMEM_READ:
  - pmem_read=1, pmem_address=u_address.
  - On pmem_resp: u_resp=1 in the same cycle with u_rdata=pmem_rdata (combinational pass-through), then IDLE.
- DRAIN:
  - pmem_write=1, pmem_address/pmem_wdata = head entry.
  - On pmem_resp: invalidate head, head+1 (wraps), count-1, then IDLE.
  - A drain is never preempted. Upstream requests wait and are then served with priority over the next drain.
- pmem_address and pmem_wdata are 0 outside PMEM_READ/DRAIN; pmem_read and pmem_write are never both 1.
- A pmem_resp arriving in IDLE or ACK is ignored.
- full, empty and count are combinational from count. Simultaneous enqueue and dequeue cannot occur.

Test Plan:
1. Assert reset mid-DRAIN with count=2 -> outputs immediately go to reset values: empty=1, count=0, pmem_write=0. After release, no drain occurs.
2. Write 0x1230 data A, no further requests -> u_resp one cycle after the request; count=1. Then DRAIN: pmem_write addr 0x1230 data A. pmem_resp -> count=0, empty=1.
3. Back-to-back writes 0x1230 A, then 0x1238 B (same line) -> each acked in 1 cycle; count stays 1; the drain writes B to 0x1230.
4. Write 0x4000 C, then immediately read 0x4004 -> u_resp one cycle after the read with u_rdata=C; pmem_read never asserted.
5. Writes to 0x0000, 0x0010, 0x0020, 0x0030 back-to-back (full=1), then a write to 0x0040 -> 0x0040 stalls; a DRAIN of 0x0000 starts. When pmem_resp is given, 0x0040 is acked; the remaining drains go out in order 0x0010, 0x0020, 0x0030, 0x0040 with correct data.
6. With 2 entries buffered, read 0x8000 (miss) -> pmem_read addr 0x8000 is issued before any drain. Give pmem_resp with data D -> u_resp in the same cycle with u_rdata=D; count stays 2.
